// File: rtl/game_pkg.sv
// game_pkg: shared definitions for the photo-booth screen flow.
//   state_e  - top-level screen states; encoding is visible on state_out.
//   H_ACTIVE - visible pixels per line. V_ACTIVE - visible lines per frame.
//   max_u    - helper used to size counters shared between screens.
package game_pkg;

    typedef enum logic [1:0] {
        StStart     = 2'd0,
        StCountdown = 2'd1,
        StCapture   = 2'd2,
        StReview    = 2'd3
    } state_e;

    localparam int unsigned H_ACTIVE = 1024;
    localparam int unsigned V_ACTIVE = 768;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/frame_timer.sv
// frame_timer: frame-tick driven down-counter.
//   clk, rst     - clock, synchronous active-high reset (count -> 0)
//   tick_i       - one-cycle frame tick
//   run_i        - counting enabled (ticks ignored when low)
//   clear_i      - force count to 0 (highest priority)
//   load_i       - load load_val_i (period in ticks)
//   load_val_i   - period to load
//   expire_o     - combinational pulse on the tick that ends the period
// The count stops at 0 and never wraps; the owner reloads or clears it.
module frame_timer #(
    parameter int unsigned Width = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_i,
    input  logic             run_i,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    output logic             expire_o
);

    logic [Width-1:0] count_q, count_d;
    logic             step;

    assign step     = run_i && tick_i && (count_q != '0);
    assign expire_o = run_i && tick_i && (count_q == Width'(1));

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (step) begin
            count_d = count_q - Width'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/screen_sequencer.sv
// screen_sequencer: START -> COUNTDOWN -> CAPTURE -> REVIEW -> START screen flow.
//   clk, rst          - pixel clock, synchronous active-high reset
//   hcount, vcount    - raster position; (0,0) is the frame tick
//   btnc_pressed      - debounced one-cycle press
//   sw_state          - enable switch gating the start press
//   start_pixel, cam_pixel, review_pixel - candidate pixel sources
//   capture_done      - pulse from the frame-capture block
//   state_out         - current state (START=0 .. REVIEW=3)
//   digit_out         - countdown digit, 0 outside COUNTDOWN
//   capture_start     - one-cycle capture request, coincides with entering CAPTURE
//   pixel_out         - registered selected pixel, black in blanking
module screen_sequencer
    import game_pkg::*;
#(
    parameter int unsigned COUNTDOWN_FRAMES = 60,
    parameter int unsigned COUNTDOWN_DIGITS = 3,
    parameter int unsigned REVIEW_FRAMES    = 300
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        btnc_pressed,
    input  logic        sw_state,
    input  logic [11:0] start_pixel,
    input  logic [11:0] cam_pixel,
    input  logic [11:0] review_pixel,
    input  logic        capture_done,
    output logic [1:0]  state_out,
    output logic [3:0]  digit_out,
    output logic        capture_start,
    output logic [11:0] pixel_out
);

    localparam int unsigned TimerW   = $clog2(max_u(COUNTDOWN_FRAMES, REVIEW_FRAMES) + 1);
    localparam logic [TimerW-1:0] CdLoad = TimerW'(COUNTDOWN_FRAMES);
    localparam logic [TimerW-1:0] RvLoad = TimerW'(REVIEW_FRAMES);
    localparam logic [3:0]  DigitLoad    = 4'(COUNTDOWN_DIGITS);

    state_e      state_q;
    logic [3:0]  digit_q;
    logic        capture_start_q;
    logic [11:0] pixel_q, pixel_d;

    logic              frame_tick;
    logic              start_press;
    logic              timer_run, timer_clear, timer_load, timer_expire;
    logic [TimerW-1:0] timer_load_val;

    assign frame_tick  = (hcount == 11'd0) && (vcount == 10'd0);
    assign start_press = btnc_pressed && sw_state;

    // Timer control mirrors the FSM transitions below: load on entry to a
    // timed screen or a new digit, clear whenever a timed screen is left.
    always_comb begin
        timer_run      = (state_q == StCountdown) || (state_q == StReview);
        timer_clear    = 1'b0;
        timer_load     = 1'b0;
        timer_load_val = CdLoad;
        unique case (state_q)
            StStart: begin
                if (start_press) timer_load = 1'b1;
            end
            StCountdown: begin
                if (timer_expire) begin
                    if (digit_q > 4'd1) timer_load  = 1'b1;
                    else                timer_clear = 1'b1;
                end
            end
            StCapture: begin
                if (capture_done) begin
                    timer_load     = 1'b1;
                    timer_load_val = RvLoad;
                end
            end
            StReview: begin
                if (btnc_pressed || timer_expire) timer_clear = 1'b1;
            end
            default: ;
        endcase
    end

    frame_timer #(
        .Width (TimerW)
    ) u_frame_timer (
        .clk        (clk),
        .rst        (rst),
        .tick_i     (frame_tick),
        .run_i      (timer_run),
        .clear_i    (timer_clear),
        .load_i     (timer_load),
        .load_val_i (timer_load_val),
        .expire_o   (timer_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StStart;
            digit_q         <= 4'd0;
            capture_start_q <= 1'b0;
        end else begin
            capture_start_q <= 1'b0;
            unique case (state_q)
                StStart: begin
                    if (start_press) begin
                        state_q <= StCountdown;
                        digit_q <= DigitLoad;
                    end
                end
                StCountdown: begin
                    if (timer_expire) begin
                        if (digit_q > 4'd1) begin
                            digit_q <= digit_q - 4'd1;
                        end else begin
                            state_q         <= StCapture;
                            digit_q         <= 4'd0;
                            capture_start_q <= 1'b1;
                        end
                    end
                end
                StCapture: begin
                    if (capture_done) state_q <= StReview;
                end
                StReview: begin
                    // Press and expiry together still give a single return.
                    if (btnc_pressed || timer_expire) state_q <= StStart;
                end
                default: state_q <= StStart;
            endcase
        end
    end

    // Source follows the state register of the cycle the raster position is
    // presented, so pixel_out lags hcount/vcount by exactly one cycle.
    always_comb begin
        pixel_d = 12'h000;
        if ((hcount < 11'(H_ACTIVE)) && (vcount < 10'(V_ACTIVE))) begin
            unique case (state_q)
                StStart:     pixel_d = start_pixel;
                StCountdown: pixel_d = cam_pixel;
                StCapture:   pixel_d = 12'h000;
                StReview:    pixel_d = review_pixel;
                default:     pixel_d = 12'h000;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_q <= 12'h000;
        end else begin
            pixel_q <= pixel_d;
        end
    end

    assign state_out     = state_q;
    assign digit_out     = digit_q;
    assign capture_start = capture_start_q;
    assign pixel_out     = pixel_q;

endmodule

// File: tb/tb_screen_sequencer.sv
module tb_screen_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        btnc_pressed, sw_state, capture_done;
    logic [11:0] start_pixel, cam_pixel, review_pixel;
    logic [1:0]  state_out;
    logic [3:0]  digit_out;
    logic        capture_start;
    logic [11:0] pixel_out;

    int checks = 0;
    int errors = 0;
    int cs_count = 0;

    screen_sequencer #(
        .COUNTDOWN_FRAMES (2),
        .COUNTDOWN_DIGITS (3),
        .REVIEW_FRAMES    (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .hcount        (hcount),
        .vcount        (vcount),
        .btnc_pressed  (btnc_pressed),
        .sw_state      (sw_state),
        .start_pixel   (start_pixel),
        .cam_pixel     (cam_pixel),
        .review_pixel  (review_pixel),
        .capture_done  (capture_done),
        .state_out     (state_out),
        .digit_out     (digit_out),
        .capture_start (capture_start),
        .pixel_out     (pixel_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (capture_start === 1'b1) cs_count++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge, then settle; inputs stay as set before the call.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One cycle with a frame tick, raster returned to an active non-tick spot.
    task automatic tick();
        hcount = 11'd0;
        vcount = 10'd0;
        step();
        hcount = 11'd100;
        vcount = 10'd100;
    endtask

    task automatic press(input logic sw);
        btnc_pressed = 1'b1;
        sw_state     = sw;
        step();
        btnc_pressed = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        hcount = 11'd100;
        vcount = 10'd100;
        btnc_pressed = 1'b0;
        sw_state = 1'b0;
        capture_done = 1'b0;
        start_pixel = 12'hABC;
        cam_pixel = 12'h456;
        review_pixel = 12'h789;
        step();
        step();
        chk("rst_state", 32'(state_out), 32'd0);
        chk("rst_digit", 32'(digit_out), 32'd0);
        chk("rst_cs", 32'(capture_start), 32'd0);
        chk("rst_pixel", 32'(pixel_out), 32'h000);
        rst = 1'b0;
        step();
        chk("start_pixel", 32'(pixel_out), 32'hABC);

        // Press with switch off is ignored; pixel tracks start_pixel.
        start_pixel = 12'h123;
        press(1'b0);
        chk("sw0_state", 32'(state_out), 32'd0);
        chk("sw0_pixel", 32'(pixel_out), 32'h123);

        // capture_done ignored outside CAPTURE.
        capture_done = 1'b1;
        step();
        capture_done = 1'b0;
        chk("cd_ignored", 32'(state_out), 32'd0);

        press(1'b1);
        chk("cd_state", 32'(state_out), 32'd1);
        chk("cd_digit3", 32'(digit_out), 32'd3);
        chk("cd_pix_prev", 32'(pixel_out), 32'h123);
        step();
        chk("cd_pix_cam", 32'(pixel_out), 32'h456);

        tick();
        chk("t1_digit", 32'(digit_out), 32'd3);
        tick();
        chk("t2_digit", 32'(digit_out), 32'd2);
        press(1'b1);
        chk("cd_press_ign", 32'(state_out), 32'd1);
        chk("cd_press_dig", 32'(digit_out), 32'd2);
        tick();
        chk("t3_digit", 32'(digit_out), 32'd2);
        tick();
        chk("t4_digit", 32'(digit_out), 32'd1);

        hcount = 11'd1030;
        step();
        hcount = 11'd100;
        chk("blank_h_cd", 32'(pixel_out), 32'h000);

        tick();
        chk("t5_digit", 32'(digit_out), 32'd1);
        chk("t5_cs", 32'(capture_start), 32'd0);
        tick();
        chk("t6_state", 32'(state_out), 32'd2);
        chk("t6_cs", 32'(capture_start), 32'd1);
        chk("t6_digit", 32'(digit_out), 32'd0);
        step();
        chk("cs_one_cycle", 32'(capture_start), 32'd0);

        // CAPTURE ignores press and frame ticks.
        btnc_pressed = 1'b1;
        tick();
        btnc_pressed = 1'b0;
        chk("cap_state", 32'(state_out), 32'd2);
        chk("cap_pixel", 32'(pixel_out), 32'h000);
        capture_done = 1'b1;
        step();
        capture_done = 1'b0;
        chk("review_state", 32'(state_out), 32'd3);
        step();
        chk("review_pixel", 32'(pixel_out), 32'h789);
        vcount = 10'd770;
        step();
        vcount = 10'd100;
        chk("blank_v_rv", 32'(pixel_out), 32'h000);

        tick();
        tick();
        tick();
        chk("rv_t3_state", 32'(state_out), 32'd3);
        tick();
        chk("rv_t4_state", 32'(state_out), 32'd0);
        chk("cs_total1", 32'(cs_count), 32'd1);

        // Second pass: leave REVIEW by a press on its first tick.
        press(1'b1);
        for (int i = 0; i < 6; i++) tick();
        chk("p2_state", 32'(state_out), 32'd2);
        capture_done = 1'b1;
        step();
        capture_done = 1'b0;
        chk("p2_review", 32'(state_out), 32'd3);
        btnc_pressed = 1'b1;
        tick();
        btnc_pressed = 1'b0;
        chk("p2_press_exit", 32'(state_out), 32'd0);
        step();
        chk("p2_start_stay", 32'(state_out), 32'd0);
        chk("cs_total2", 32'(cs_count), 32'd2);

        // Reset mid-countdown aborts without a capture request.
        press(1'b1);
        tick();
        tick();
        chk("rs_digit2", 32'(digit_out), 32'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rs_state", 32'(state_out), 32'd0);
        chk("rs_digit", 32'(digit_out), 32'd0);
        chk("rs_pixel", 32'(pixel_out), 32'h000);
        for (int i = 0; i < 6; i++) tick();
        chk("rs_still_start", 32'(state_out), 32'd0);
        chk("rs_no_cs", 32'(cs_count), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/screen_sequencer.md
SCREEN_SEQUENCER -- requirements
Module: screen_sequencer

Interface
REQ-001 SHALL have parameter COUNTDOWN_FRAMES, default 60, meaning frames per countdown digit.
REQ-002 SHALL have parameter COUNTDOWN_DIGITS, default 3, meaning the countdown start digit (counts COUNTDOWN_DIGITS..1).
REQ-003 SHALL have parameter REVIEW_FRAMES, default 300, meaning frames the review screen is shown before returning to start.
REQ-004 SHALL have port clk, input, 1, pixel clock.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port hcount, input, 11, horizontal pixel position.
REQ-007 SHALL have port vcount, input, 10, vertical pixel position.
REQ-008 SHALL have port btnc_pressed, input, 1, single-cycle debounced press pulse.
REQ-009 SHALL have port sw_state, input, 1, enable switch gating the start press.
REQ-010 SHALL have ports start_pixel, cam_pixel and review_pixel, each input, 12, candidate pixel sources.
REQ-011 SHALL have port capture_done, input, 1, pulse from the frame-capture block.
REQ-012 SHALL have port state_out, output, 2, current state (START=0, COUNTDOWN=1, CAPTURE=2, REVIEW=3).
REQ-013 SHALL have port digit_out, output, 4, current countdown digit, 0 outside COUNTDOWN.
REQ-014 SHALL have port capture_start, output, 1, single-cycle capture request.
REQ-015 SHALL have port pixel_out, output, 12, selected pixel.

Function
REQ-016 Frame tick SHALL be hcount==0 && vcount==0, evaluated each cycle.
REQ-017 START: on btnc_pressed && sw_state -> COUNTDOWN next cycle; digit loaded to COUNTDOWN_DIGITS; frame counter cleared. A press with sw_state=0 is ignored.
REQ-018 COUNTDOWN: frame counter increments on each frame tick; at COUNTDOWN_FRAMES ticks it clears and digit decrements.
REQ-019 When digit==1 and the counter expires, the FSM SHALL enter CAPTURE on that tick cycle and assert capture_start for exactly that one cycle.
REQ-020 CAPTURE: wait for capture_done -> REVIEW; frame counter cleared on entry to REVIEW.
REQ-021 REVIEW: btnc_pressed or REVIEW_FRAMES frame ticks -> START; press and expiry in the same cycle produce one transition.
REQ-022 btnc_pressed SHALL be ignored in COUNTDOWN and CAPTURE; capture_done SHALL be ignored outside CAPTURE.
REQ-023 Pixel source: START=start_pixel, COUNTDOWN=cam_pixel, CAPTURE=12'h000, REVIEW=review_pixel.
REQ-024 pixel_out SHALL be registered with 1-cycle latency from hcount/vcount and source inputs, with selection based on the state in that same cycle.
REQ-025 pixel_out SHALL be 12'h000 when hcount>=1024 or vcount>=768 (blanking).
REQ-026 Frame counters SHALL be sized for max(COUNTDOWN_FRAMES, REVIEW_FRAMES) and never wrap (clear on expiry or state exit).

Reset
REQ-027 On rst: state START, counters 0, digit_out 0, capture_start 0, pixel_out 12'h000, all applied the cycle after rst is sampled high.
REQ-028 rst mid-COUNTDOWN or mid-CAPTURE SHALL abort to START with no capture_start emitted.

Structure
REQ-029 State enum and H_ACTIVE=1024, V_ACTIVE=768 SHALL live in shared package game_pkg.
REQ-030 One sub-module frame_timer (frame-tick-driven counter with load, clear and expire pulse) SHALL be instantiated and shared by COUNTDOWN and REVIEW.

Verification (COUNTDOWN_FRAMES=2, COUNTDOWN_DIGITS=3, REVIEW_FRAMES=4)
REQ-031 Press with sw_state=0 in START -> state stays 0, pixel_out tracks start_pixel one cycle later.
REQ-032 Press with sw_state=1 -> state 1, digit 3; digits 3,2,1 each last 2 frame ticks; capture_start is one cycle wide at the 6th tick; state 2.
REQ-033 In CAPTURE, press plus hcount=0, vcount=0 -> still state 2, pixel_out 0; capture_done -> state 3.
REQ-034 REVIEW with no press -> state 0 on the 4th tick; repeat with press at tick 1 -> state 0 next cycle.
REQ-035 hcount=1030 or vcount=770 in any state -> pixel_out 12'h000.
REQ-036 rst asserted at digit 2 -> state 0, digit_out 0, and no capture_start observed.
